// File: rtl/pipeline_hazard_controller.sv
// ID-stage hazard controller: detects load-use and ALU-to-branch RAW hazards, holds PC/IF-ID
// for one or two cycles, squashes IF/ID on redirects, and keeps saturating stall/flush counters.
module pipeline_hazard_controller #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           if_id_rs,
  input  logic [4:0]           if_id_rt,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  input  logic                 id_is_branch,
  input  logic                 id_ex_mem_read,
  input  logic                 id_ex_reg_write,
  input  logic [4:0]           id_ex_rd,
  input  logic                 branch_taken,
  input  logic                 jump,
  output logic                 Data_Hazard,
  output logic                 IF_Flush,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  typedef enum logic [0:0] {StRun, StStall} state_e;

  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic [1:0]           rem_q, rem_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic match_rs, match_rt, any_match;
  logic load_hazard, alu_br_hazard, hazard;
  logic stall, stall_act, flush_act;

  // r0 is hardwired zero, so a write to it can never feed a reader.
  assign match_rs      = id_uses_rs && (if_id_rs == id_ex_rd) && (id_ex_rd != 5'd0);
  assign match_rt      = id_uses_rt && (if_id_rt == id_ex_rd) && (id_ex_rd != 5'd0);
  assign any_match     = match_rs || match_rt;
  assign load_hazard   = id_ex_mem_read && any_match;
  assign alu_br_hazard = id_is_branch && id_ex_reg_write && !id_ex_mem_read && any_match;
  assign hazard        = load_hazard || alu_br_hazard;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall   = 1'b0;
    unique case (state_q)
      StRun: begin
        if (hazard) begin
          stall = 1'b1;
          // A branch compared in ID needs the load data one cycle later than an ALU op.
          if (load_hazard && id_is_branch) begin
            state_d = StStall;
            rem_d   = 2'd1;
          end
        end
      end
      StStall: begin
        stall = 1'b1;
        rem_d = rem_q - 2'd1;
        if (rem_q <= 2'd1) begin
          state_d = StRun;
          rem_d   = 2'd0;
        end
      end
    endcase
  end

  // Outputs are forced to their idle values while reset is held, independent of the clock.
  assign stall_act   = reset && stall;
  assign flush_act   = reset && !stall && (branch_taken || jump);
  assign Data_Hazard = !stall_act;
  assign pc_write    = !stall_act;
  assign if_id_write = !stall_act;
  assign IF_Flush    = flush_act;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_act && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CntOne;
    if (flush_act && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CntOne;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StRun;
      rem_q       <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter CNT_WIDTH, default 16, width of each performance counter.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 if_id_rs, if_id_rt  input  5 each  source register fields of the instruction in ID.
REQ-005 id_uses_rs, id_uses_rt  input  1 each  the ID instruction reads rs / rt.
REQ-006 id_is_branch  input  1  the ID instruction is a branch compared in ID.
REQ-007 id_ex_mem_read, id_ex_reg_write  input  1 each  load / register-write flags of the EX-stage instruction.
REQ-008 id_ex_rd  input  5  destination register of the EX-stage instruction.
REQ-009 branch_taken, jump  input  1 each  redirect indications from ID.
REQ-010 Data_Hazard  output  1  1 = no hazard, 0 = insert bubble; feeds the ID control-zeroing mux.
REQ-011 IF_Flush  output  1  1 = squash the IF/ID instruction.
REQ-012 pc_write, if_id_write  output  1 each  PC and IF/ID register enables; 0 = hold.
REQ-013 stall_count, flush_count  output  CNT_WIDTH each  saturating event counters.

Function
REQ-014 match_rs SHALL be id_uses_rs AND (if_id_rs == id_ex_rd) AND (id_ex_rd != 0); match_rt likewise with rt.
REQ-015 Hazard condition: (id_ex_mem_read AND (match_rs OR match_rt)), or (id_is_branch AND id_ex_reg_write AND NOT id_ex_mem_read AND (match_rs OR match_rt)).
REQ-016 Stall length N SHALL be 2 for a load match with id_is_branch=1, else 1.
REQ-017 States: RUN, STALL; 2-bit remaining-stall counter rem.
REQ-018 In RUN with the hazard condition true, the controller SHALL stall in the same cycle (combinational) and, at the next edge, enter STALL with rem=N-1 when N=2, else stay in RUN.
REQ-019 In STALL, the controller SHALL stall unconditionally, ignore hazard inputs, decrement rem each edge, and return to RUN when rem reaches 0.
REQ-020 A stall cycle SHALL drive Data_Hazard=0, pc_write=0, if_id_write=0, IF_Flush=0.
REQ-021 A non-stall cycle SHALL drive Data_Hazard=1, pc_write=1, if_id_write=1, IF_Flush=(branch_taken OR jump).
REQ-022 Stall SHALL take priority over flush; branch_taken/jump arriving during a stall cycle SHALL be ignored.
REQ-023 stall_count SHALL increment once per stall cycle and flush_count once per cycle with IF_Flush=1; each SHALL saturate at all-ones and never wrap.
REQ-024 Register 0 SHALL never create a hazard.

Reset
REQ-025 While reset=0: state=RUN, rem=0, counters=0, Data_Hazard=1, pc_write=1, if_id_write=1, IF_Flush=0, asynchronously.
REQ-026 Reset asserted mid-STALL SHALL abort the stall immediately; the first cycle after release evaluates from RUN.

Verification
REQ-027 Load to r5 in EX, ID add reads r5 -> one cycle Data_Hazard=0, pc_write=0; next cycle (new inputs clear) Data_Hazard=1; stall_count=1.
REQ-028 Load to r5 in EX, ID beq reads r5 -> exactly 2 consecutive stall cycles regardless of inputs in the 2nd cycle; stall_count=2.
REQ-029 ALU write to r3 in EX, ID beq reads r3 -> 1 stall cycle; same with id_ex_rd=0 -> 0 stall cycles.
REQ-030 branch_taken=1, no hazard -> IF_Flush=1 that cycle, flush_count+1; branch_taken=1 during STALL -> IF_Flush=0, flush_count unchanged.
REQ-031 CNT_WIDTH=4, 20 stall cycles -> stall_count holds 15.
REQ-032 Reset pulled low during first cycle of a 2-cycle stall -> outputs return to reset values at once; counters=0 after release.
